cbus_tx_framer: RTL and testbench



---
 rtl/cbus_pkg.sv | 37 +++
 rtl/cbus_rr_arb.sv | 43 ++++
 rtl/cbus_tx_framer.sv | 178 +++++++++++++++++
 tb/tb_cbus_tx_framer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_pkg.sv
// Cbus TX framer shared definitions: K characters, FSM states, CRC-8 step.
// The CRC-8 step is only used when CBUS_TX_CRC8_EN is defined.
package cbus_pkg;

    localparam logic [7:0] K_IDLE    = 8'hBC;
    localparam logic [7:0] K_SOF     = 8'hFB;
    localparam logic [7:0] K_EOF     = 8'hFD;
    localparam logic [7:0] K_EOF_ERR = 8'hFE;
    localparam logic [7:0] K_PAD     = 8'h1C;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_CHID,
        ST_DATA,
        ST_CRC,
        ST_EOF,
        ST_TRUNC,
        ST_DROP,
        ST_GAP
    } tx_state_t;

    // Poly 0x07, MSB first, one byte per call.
    function automatic logic [7:0] crc8_next(
        input logic [7:0] data,
        input logic [7:0] crc
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07)
                     : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/cbus_rr_arb.sv
// Round-robin channel arbiter for the Cbus TX framer.
// Grants the first requester at or after the stored pointer.
module cbus_rr_arb #(
    parameter  int NUM_CH = 4,
    localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              upd,
    input  logic [PW-1:0]     new_ptr,
    output logic [PW-1:0]     grant,
    output logic              any_req
);

    logic [PW-1:0] ptr_q;
    logic          found;
    int            idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (upd) begin
            ptr_q <= new_ptr;
        end
    end

    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CH;
            if (!found && req[idx]) begin
                grant = PW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/cbus_tx_framer.sv
// Multi-channel Cbus TX framer: RR arbitration, SOF/CHID/payload/EOF framing.
// Define CBUS_TX_CRC8_EN to append a CRC-8 data character before EOF.
module cbus_tx_framer
    import cbus_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 256,
    parameter int IFG_MIN = 2
) (
    input  logic                core_clk,
    input  logic                core_reset_n,
    input  logic [NUM_CH*8-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]   s_axis_tvalid,
    input  logic [NUM_CH-1:0]   s_axis_tlast,
    output logic [NUM_CH-1:0]   s_axis_tready,
    output logic [7:0]          pcs_txdata,
    output logic                pcs_txcharisk,
    output logic [3:0]          pcs_txseq,
    output logic [15:0]         stat_frames,
    output logic [7:0]          stat_trunc
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int GW = $clog2(IFG_MIN + 1);

    tx_state_t     state;
    logic [PW-1:0] grant_q;
    logic [PW-1:0] arb_grant;
    logic [PW-1:0] next_ptr;
    logic          any_req;
    logic          gap_done;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic [LW-1:0] len_q;
    logic [GW-1:0] gap_q;
`ifdef CBUS_TX_CRC8_EN
    logic [7:0]    crc_q;
`endif

    assign g_valid  = s_axis_tvalid[grant_q];
    assign g_last   = s_axis_tlast[grant_q];
    assign g_data   = s_axis_tdata[{grant_q, 3'b000} +: 8];
    assign gap_done = (state == ST_GAP)
                   && (gap_q == GW'(IFG_MIN - 1));
    assign next_ptr = (grant_q == PW'(NUM_CH - 1))
                    ? '0 : grant_q + 1'b1;

    always_comb begin
        s_axis_tready = '0;
        if (state == ST_DATA || state == ST_DROP) begin
            s_axis_tready[grant_q] = 1'b1;
        end
    end

    cbus_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (core_clk),
        .rst_n   (core_reset_n),
        .req     (s_axis_tvalid),
        .upd     (gap_done),
        .new_ptr (next_ptr),
        .grant   (arb_grant),
        .any_req (any_req)
    );

    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state         <= ST_IDLE;
            pcs_txdata    <= K_IDLE;
            pcs_txcharisk <= 1'b1;
            pcs_txseq     <= 4'd0;
            stat_frames   <= 16'd0;
            stat_trunc    <= 8'd0;
            grant_q       <= '0;
            len_q         <= '0;
            gap_q         <= '0;
`ifdef CBUS_TX_CRC8_EN
            crc_q         <= 8'h00;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    pcs_txdata    <= K_IDLE;
                    pcs_txcharisk <= 1'b1;
                    if (any_req) begin
                        grant_q <= arb_grant;
                        state   <= ST_SOF;
                    end
                end
                ST_SOF: begin
                    pcs_txdata    <= K_SOF;
                    pcs_txcharisk <= 1'b1;
                    pcs_txseq     <= pcs_txseq + 4'd1;
                    state         <= ST_CHID;
                end
                ST_CHID: begin
                    pcs_txdata    <= 8'(grant_q);
                    pcs_txcharisk <= 1'b0;
                    len_q         <= '0;
`ifdef CBUS_TX_CRC8_EN
                    crc_q <= crc8_next(8'(grant_q), 8'h00);
`endif
                    state         <= ST_DATA;
                end
                ST_DATA: begin
                    if (g_valid) begin
                        pcs_txdata    <= g_data;
                        pcs_txcharisk <= 1'b0;
                        len_q         <= len_q + 1'b1;
`ifdef CBUS_TX_CRC8_EN
                        crc_q <= crc8_next(g_data, crc_q);
`endif
                        if (g_last) begin
`ifdef CBUS_TX_CRC8_EN
                            state <= ST_CRC;
`else
                            state <= ST_EOF;
`endif
                        end else if (len_q == LW'(MAX_LEN - 1)) begin
                            state <= ST_TRUNC;
                        end
                    end else begin
                        pcs_txdata    <= K_PAD;
                        pcs_txcharisk <= 1'b1;
                    end
                end
`ifdef CBUS_TX_CRC8_EN
                ST_CRC: begin
                    pcs_txdata    <= crc_q;
                    pcs_txcharisk <= 1'b0;
                    state         <= ST_EOF;
                end
`endif
                ST_EOF: begin
                    pcs_txdata    <= K_EOF;
                    pcs_txcharisk <= 1'b1;
                    stat_frames   <= stat_frames + 16'd1;
                    gap_q         <= '0;
                    state         <= ST_GAP;
                end
                ST_TRUNC: begin
                    pcs_txdata    <= K_EOF_ERR;
                    pcs_txcharisk <= 1'b1;
                    if (stat_trunc != 8'hFF) begin
                        stat_trunc <= stat_trunc + 8'd1;
                    end
                    state         <= ST_DROP;
                end
                ST_DROP: begin
                    pcs_txdata    <= K_IDLE;
                    pcs_txcharisk <= 1'b1;
                    if (g_valid && g_last) begin
                        gap_q <= '0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    pcs_txdata    <= K_IDLE;
                    pcs_txcharisk <= 1'b1;
                    if (gap_done) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    pcs_txdata    <= K_IDLE;
                    pcs_txcharisk <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_tx_framer.sv
// Randomized bench for cbus_tx_framer against a frame-level stream model.
// Expected characters, sequence numbers and counters come from the model.
module tb_cbus_tx_framer;

    localparam int NCH  = 4;
    localparam int MAXL = 4;
    localparam int IFG  = 2;

    localparam logic [8:0] C_IDLE = 9'h1BC;
    localparam logic [8:0] C_SOF  = 9'h1FB;
    localparam logic [8:0] C_EOF  = 9'h1FD;
    localparam logic [8:0] C_ERR  = 9'h1FE;
    localparam logic [8:0] C_PAD  = 9'h11C;

    typedef struct {
        logic [8:0] ch;
        logic [3:0] seq;
        logic       sof;
        logic       gapchk;
        logic       term;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [NCH*8-1:0] s_axis_tdata;
    logic [NCH-1:0]   s_axis_tvalid;
    logic [NCH-1:0]   s_axis_tlast;
    logic [NCH-1:0]   s_axis_tready;
    logic [7:0]       pcs_txdata;
    logic             pcs_txcharisk;
    logic [3:0]       pcs_txseq;
    logic [15:0]      stat_frames;
    logic [7:0]       stat_trunc;

    // Source entries: {delay[3:0], last, data[7:0]}
    logic [12:0]    srcq [NCH][$];
    logic [12:0]    mq   [NCH][$];
    exp_t           exp_q[$];
    logic [NCH-1:0] vld;
    logic [NCH-1:0] loaded;
    logic [NCH-1:0] hs;
    int             dly [NCH];
    int             n_chk;
    int             n_fail;
    int             idle_run;
    logic           in_frame;
    int             m_ptr;
    int             m_seq;
    int             m_frames;
    int             m_trunc;

    cbus_tx_framer #(
        .NUM_CH  (NCH),
        .MAX_LEN (MAXL),
        .IFG_MIN (IFG)
    ) dut (
        .core_clk      (clk),
        .core_reset_n  (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .pcs_txdata    (pcs_txdata),
        .pcs_txcharisk (pcs_txcharisk),
        .pcs_txseq     (pcs_txseq),
        .stat_frames   (stat_frames),
        .stat_trunc    (stat_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     tag, got, want);
        end
    endtask

    function automatic logic [7:0] crc_bits(input logic [7:0] crc,
                                            input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic push_exp(input logic [8:0] ch, input logic sof,
                            input logic gapchk, input logic term);
        exp_t e;
        e.ch     = ch;
        e.seq    = 4'(m_seq);
        e.sof    = sof;
        e.gapchk = gapchk;
        e.term   = term;
        exp_q.push_back(e);
    endtask

    task automatic add_byte(input int c, input logic [7:0] d,
                            input logic last, input int dl);
        srcq[c].push_back({4'(dl), last, d});
        mq[c].push_back({4'(dl), last, d});
    endtask

    task automatic add_pkt_rand(input int c);
        int len;
        int dl;
        len = $urandom_range(1, 7);
        for (int i = 0; i < len; i++) begin
            dl = 0;
            if (i > 0 && $urandom_range(0, 3) == 0)
                dl = $urandom_range(1, 3);
            add_byte(c, 8'($urandom), i == len - 1, dl);
        end
    endtask

    // Every loaded channel requests at once; frames follow round-robin order.
    task automatic build_expected();
        bit          first;
        bit          prev_trunc;
        bit          trunc;
        int          c;
        int          n;
        logic [12:0] e;
        logic [7:0]  crc;
        first      = 1'b1;
        prev_trunc = 1'b0;
        forever begin
            c = -1;
            for (int i = 0; i < NCH; i++) begin
                if (c < 0 && mq[(m_ptr + i) % NCH].size() > 0)
                    c = (m_ptr + i) % NCH;
            end
            if (c < 0) break;
            m_ptr = (c + 1) % NCH;
            m_seq = (m_seq + 1) % 16;
            push_exp(C_SOF, 1'b1, !first && !prev_trunc, 1'b0);
            push_exp({1'b0, 8'(c)}, 1'b0, 1'b0, 1'b0);
            crc = crc_bits(8'h00, 8'(c));
            n   = 0;
            do begin
                e = mq[c].pop_front();
                n++;
                if (n <= MAXL) begin
                    if (n > 1) begin
                        for (int p = 0; p < int'(e[12:9]); p++)
                            push_exp(C_PAD, 1'b0, 1'b0, 1'b0);
                    end
                    push_exp({1'b0, e[7:0]}, 1'b0, 1'b0, 1'b0);
                    crc = crc_bits(crc, e[7:0]);
                end
            end while (!e[8]);
            trunc = n > MAXL;
`ifdef CBUS_TX_CRC8_EN
            if (!trunc) push_exp({1'b0, crc}, 1'b0, 1'b0, 1'b0);
`endif
            push_exp(trunc ? C_ERR : C_EOF, 1'b0, 1'b0, 1'b1);
            if (trunc) begin
                if (m_trunc < 255) m_trunc++;
            end else begin
                m_frames = (m_frames + 1) % 65536;
            end
            first      = 1'b0;
            prev_trunc = trunc;
        end
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int c = 0; c < NCH; c++)
            if (srcq[c].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic monitor_step();
        logic [8:0] ch;
        exp_t       e;
        ch = {pcs_txcharisk, pcs_txdata};
        check("tready_onehot",
              32'($onehot0(s_axis_tready)), 32'd1);
        if (!in_frame && ch == C_IDLE) begin
            idle_run++;
        end else if (exp_q.size() == 0) begin
            check("stray_char", 32'(ch), 32'(C_IDLE));
        end else begin
            e = exp_q.pop_front();
            check(e.sof ? "sof_char" : "frame_char",
                  32'(ch), 32'(e.ch));
            if (e.sof) begin
                check("txseq", 32'(pcs_txseq), 32'(e.seq));
                if (e.gapchk)
                    check("ifg_idles", idle_run, IFG + 1);
                in_frame = 1'b1;
            end
            if (e.term) begin
                in_frame = 1'b0;
                idle_run = 0;
            end
        end
    endtask

    task automatic drive_step();
        for (int c = 0; c < NCH; c++) begin
            if (hs[c]) begin
                void'(srcq[c].pop_front());
                vld[c]    = 1'b0;
                loaded[c] = 1'b0;
            end
            if (!vld[c] && srcq[c].size() > 0) begin
                if (!loaded[c]) begin
                    dly[c]    = int'(srcq[c][0][12:9]);
                    loaded[c] = 1'b1;
                end
                if (dly[c] == 0) vld[c] = 1'b1;
                else             dly[c]--;
            end
        end
    endtask

    task automatic apply_inputs();
        for (int c = 0; c < NCH; c++) begin
            s_axis_tdata[c*8 +: 8] = (srcq[c].size() > 0)
                                   ? srcq[c][0][7:0] : 8'h00;
            s_axis_tlast[c] = (srcq[c].size() > 0)
                            ? srcq[c][0][8] : 1'b0;
        end
        s_axis_tvalid = vld;
    endtask

    // AXIS sources and stream monitor share one loop.
    initial begin
        vld      = '0;
        loaded   = '0;
        hs       = '0;
        in_frame = 1'b0;
        idle_run = 0;
        for (int c = 0; c < NCH; c++) dly[c] = 0;
        apply_inputs();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs       = '0;
                in_frame = 1'b0;
                idle_run = 0;
            end else begin
                monitor_step();
                hs = s_axis_tvalid & s_axis_tready;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                vld    = '0;
                loaded = '0;
            end else begin
                drive_step();
            end
            apply_inputs();
        end
    end

    task automatic run_batch();
        int cyc;
        cyc = 0;
        build_expected();
        while ((exp_q.size() > 0 || pending()) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 3000) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (IFG + 4) @(posedge clk);
        @(negedge clk);
        check("stat_frames", 32'(stat_frames), m_frames);
        check("stat_trunc", 32'(stat_trunc), m_trunc);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        m_ptr    = 0;
        m_seq    = 0;
        m_frames = 0;
        m_trunc  = 0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txdata", 32'(pcs_txdata), 32'h0BC);
        check("rst_charisk", 32'(pcs_txcharisk), 32'd1);
        check("rst_txseq", 32'(pcs_txseq), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_frames", 32'(stat_frames), 32'd0);
        check("rst_trunc", 32'(stat_trunc), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single 3-byte frame on ch0.
        @(negedge clk);
        add_byte(0, 8'h11, 1'b0, 0);
        add_byte(0, 8'h22, 1'b0, 0);
        add_byte(0, 8'h33, 1'b1, 0);
        run_batch();
        check("t1_txseq", 32'(pcs_txseq), 32'd1);

        // ch1 and ch2 together, then ch0 and ch3 together.
        add_byte(1, 8'hA1, 1'b0, 0);
        add_byte(1, 8'hA2, 1'b1, 0);
        add_byte(2, 8'hB1, 1'b0, 0);
        add_byte(2, 8'hB2, 1'b1, 0);
        run_batch();
        add_byte(0, 8'hC1, 1'b0, 0);
        add_byte(0, 8'hC2, 1'b1, 0);
        add_byte(3, 8'hD1, 1'b0, 0);
        add_byte(3, 8'hD2, 1'b1, 0);
        run_batch();

        // Two-cycle valid gap mid-frame, tlast exactly at the length limit.
        add_byte(0, 8'h41, 1'b0, 0);
        add_byte(0, 8'h42, 1'b0, 2);
        add_byte(0, 8'h43, 1'b0, 0);
        add_byte(0, 8'h44, 1'b1, 0);
        run_batch();

        // Six bytes against a limit of four.
        for (int i = 0; i < 6; i++)
            add_byte(0, 8'(8'h50 + i), i == 5, 0);
        run_batch();
        check("trunc_one", 32'(stat_trunc), 32'd1);

        // Reset in the middle of a frame.
        add_byte(0, 8'h61, 1'b0, 0);
        add_byte(0, 8'h62, 1'b0, 0);
        add_byte(0, 8'h63, 1'b0, 10);
        add_byte(0, 8'h64, 1'b1, 0);
        build_expected();
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_txdata", 32'(pcs_txdata), 32'h0BC);
        check("mid_rst_charisk", 32'(pcs_txcharisk), 32'd1);
        check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        check("mid_rst_frames", 32'(stat_frames), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            srcq[c].delete();
            mq[c].delete();
        end
        exp_q.delete();
        m_ptr    = 0;
        m_seq    = 0;
        m_frames = 0;
        m_trunc  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        add_byte(0, 8'h71, 1'b0, 0);
        add_byte(0, 8'h72, 1'b1, 0);
        run_batch();
        check("post_rst_txseq", 32'(pcs_txseq), 32'd1);

        // Random traffic on all channels.
        for (int b = 0; b < 25; b++) begin
            for (int c = 0; c < NCH; c++) begin
                repeat ($urandom_range(0, 2)) add_pkt_rand(c);
            end
            run_batch();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
